// File: rtl/acc_alu_pkg.sv
// acc_alu_pkg: opcode encodings, class fields and FSM state type for acc_alu
package acc_alu_pkg;
  localparam logic [1:0] CLS_CTRL  = 2'b00;
  localparam logic [1:0] CLS_ARITH = 2'b01;
  localparam logic [1:0] CLS_LOGIC = 2'b10;
  localparam logic [1:0] CLS_SHIFT = 2'b11;
  localparam logic [3:0] OP_NOOP  = {CLS_CTRL, 2'b00};
  localparam logic [3:0] OP_RESET = {CLS_CTRL, 2'b01};
  localparam logic [3:0] OP_LOAD  = {CLS_ARITH, 2'b00};
  localparam logic [3:0] OP_ADD   = {CLS_ARITH, 2'b01};
  localparam logic [3:0] OP_SUB   = {CLS_ARITH, 2'b10};
  localparam logic [3:0] OP_MUL   = {CLS_ARITH, 2'b11};
  localparam logic [3:0] OP_AND   = {CLS_LOGIC, 2'b01};
  localparam logic [3:0] OP_OR    = {CLS_LOGIC, 2'b10};
  localparam logic [3:0] OP_XOR   = {CLS_LOGIC, 2'b11};
  localparam logic [3:0] OP_SHL   = {CLS_SHIFT, 2'b00};
  localparam logic [3:0] OP_SHR   = {CLS_SHIFT, 2'b01};
  typedef enum logic {ST_IDLE, ST_MUL} state_t;
endpackage

// File: rtl/acc_alu_serial_mul.sv
// acc_alu_serial_mul: W-cycle unsigned shift-add multiplier; o_last/o_prod mark the final step
module acc_alu_serial_mul #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_start,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic           o_last,
  output logic [2*W-1:0] o_prod
);
  localparam int CW = $clog2(W + 1);
  logic [W-1:0]   r_a;
  logic [2*W-1:0] r_p;
  logic [CW-1:0]  r_cnt;
  logic [W:0]     w_sum;
  // upper half accumulates partial sums while the multiplier shifts out of the lower half
  assign w_sum  = {1'b0, r_p[2*W-1:W]} + (r_p[0] ? {1'b0, r_a} : '0);
  assign o_prod = {w_sum, r_p[W-1:1]};
  assign o_last = r_cnt == CW'(1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a   <= '0;
      r_p   <= '0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_a   <= i_a;
      r_p   <= {{W{1'b0}}, i_b};
      r_cnt <= CW'(W);
    end else if (r_cnt != '0) begin
      r_p   <= o_prod;
      r_cnt <= r_cnt - CW'(1);
    end
  end
endmodule

// File: rtl/acc_alu.sv
// acc_alu: W-bit accumulator ALU with valid/ready input, status flags and pulses.
// Define ACC_ALU_MUL_EN to build the serial multiplier behind opcode 0111.
module acc_alu
  import acc_alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   opcode,
  input  logic [W-1:0] operand,
  output logic [W-1:0] acc,
  output logic         carry,
  output logic         zero,
  output logic         ovf,
  output logic         ill,
  output logic         done
);
  logic           w_accept, w_ill, w_mul_start, w_mul_done;
  logic           w_carry_n, w_ovf_n;
  logic [W-1:0]   w_acc_n;
  logic [W:0]     w_sum, w_diff;
  logic [2*W-1:0] w_prod;
  assign w_accept = in_valid & in_ready;
  assign zero     = acc == '0;
`ifdef ACC_ALU_MUL_EN
  state_t r_state, w_state_n;
  assign w_mul_start = w_accept && opcode == OP_MUL;
  assign in_ready    = r_state == ST_IDLE;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else r_state <= w_state_n;
  end
  always_comb begin
    w_state_n = r_state;
    if (r_state == ST_IDLE) w_state_n = w_mul_start ? ST_MUL : ST_IDLE;
    else w_state_n = w_mul_done ? ST_IDLE : ST_MUL;
  end
  acc_alu_serial_mul #(.W(W)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_mul_start),
    .i_a     (acc),
    .i_b     (operand),
    .o_last  (w_mul_done),
    .o_prod  (w_prod)
  );
`else
  assign w_mul_start = 1'b0;
  assign w_mul_done  = 1'b0;
  assign w_prod      = '0;
  assign in_ready    = 1'b1;
`endif
  always_comb begin
    w_sum     = {1'b0, acc} + {1'b0, operand};
    w_diff    = {1'b0, acc} - {1'b0, operand};
    w_acc_n   = acc;
    w_carry_n = carry;
    w_ovf_n   = ovf;
    w_ill     = 1'b0;
    case (opcode)
      OP_NOOP: ;
      OP_RESET: begin
        w_acc_n   = '0;
        w_carry_n = 1'b0;
        w_ovf_n   = 1'b0;
      end
      OP_LOAD: begin
        w_acc_n   = operand;
        w_carry_n = 1'b0;
        w_ovf_n   = 1'b0;
      end
      OP_ADD: begin
        w_acc_n   = w_sum[W-1:0];
        w_carry_n = w_sum[W];
        w_ovf_n   = (acc[W-1] == operand[W-1]) && (w_sum[W-1] != acc[W-1]);
      end
      OP_SUB: begin
        w_acc_n   = w_diff[W-1:0];
        w_carry_n = w_diff[W];
        w_ovf_n   = (acc[W-1] != operand[W-1]) && (w_diff[W-1] != acc[W-1]);
      end
`ifdef ACC_ALU_MUL_EN
      OP_MUL: ;
`endif
      OP_AND: begin
        w_acc_n   = acc & operand;
        w_carry_n = 1'b0;
        w_ovf_n   = 1'b0;
      end
      OP_OR: begin
        w_acc_n   = acc | operand;
        w_carry_n = 1'b0;
        w_ovf_n   = 1'b0;
      end
      OP_XOR: begin
        w_acc_n   = acc ^ operand;
        w_carry_n = 1'b0;
        w_ovf_n   = 1'b0;
      end
      OP_SHL: begin
        {w_carry_n, w_acc_n} = {acc, 1'b0};
        w_ovf_n              = 1'b0;
      end
      OP_SHR: begin
        {w_acc_n, w_carry_n} = {1'b0, acc};
        w_ovf_n              = 1'b0;
      end
      default: w_ill = 1'b1;
    endcase
    if (w_mul_done) begin
      w_acc_n   = w_prod[W-1:0];
      w_carry_n = |w_prod[2*W-1:W];
      w_ovf_n   = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc   <= '0;
      carry <= 1'b0;
      ovf   <= 1'b0;
      ill   <= 1'b0;
      done  <= 1'b0;
    end else begin
      ill  <= w_accept & w_ill;
      done <= (w_accept & ~w_mul_start) | w_mul_done;
      if (w_accept | w_mul_done) begin
        acc   <= w_acc_n;
        carry <= w_carry_n;
        ovf   <= w_ovf_n;
      end
    end
  end
endmodule
